// File: rtl/conv_window_feeder.sv
// conv_window_feeder: ping-pong window buffer that streams lane-packed beats into a convolution unit
// Ports: clk, rst (async, active-low); en (0 aborts to idle); cfg_kernel_size (3 or 5);
//        in_valid/in_ready/in_data (upstream beat, weight in the top DATA_WIDTH bits);
//        conv_rst_n, conv_input_data, conv_weight, conv_kernel_size (to the convolution unit);
//        conv_result_ready (window-done pulse); cfg_error, underrun (status).
// Optional: define CONV_FEEDER_STATS_EN to add window_count, a wrapping count of completed windows.
module conv_window_feeder #(
   parameter int DATA_WIDTH        = 16,
   parameter int PARA_X            = 3,
   parameter int PARA_Y            = 3,
   parameter int KERNEL_SIZE_MAX   = 5,
   parameter int KERNEL_SIZE_WIDTH = 3
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           en,
   input  logic [KERNEL_SIZE_WIDTH-1:0]                   cfg_kernel_size,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [PARA_X*PARA_Y*DATA_WIDTH+DATA_WIDTH-1:0] in_data,
   output logic                                           conv_rst_n,
   output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]            conv_input_data,
   output logic [DATA_WIDTH-1:0]                          conv_weight,
   output logic [KERNEL_SIZE_WIDTH-1:0]                   conv_kernel_size,
   input  logic                                           conv_result_ready,
   output logic                                           cfg_error,
`ifdef CONV_FEEDER_STATS_EN
   output logic [15:0]                                    window_count,
`endif
   output logic                                           underrun
);
   localparam int BEAT_W = PARA_X*PARA_Y*DATA_WIDTH;
   localparam int W      = BEAT_W+DATA_WIDTH;
   localparam int DEPTH  = KERNEL_SIZE_MAX*KERNEL_SIZE_MAX;
   localparam int AW     = $clog2(DEPTH+1);
   typedef enum logic [2:0] {IDLE, FILL, PRIME, STREAM, WAIT, STALL} state_t;
   state_t                       state;
   logic [W-1:0]                 mem [2][DEPTH];
   logic                         fill_sel, wr, swap, full, last, legal, rd_bank, wr_bank;
   logic [AW-1:0]                fill_cnt, idx, kk, rd_idx, wr_slot;
   logic [KERNEL_SIZE_WIDTH-1:0] k;
   assign kk               = AW'(k) * AW'(k);
   assign full             = fill_cnt == kk;
   assign last             = idx == kk - AW'(1);
   assign legal            = cfg_kernel_size == KERNEL_SIZE_WIDTH'(3) || cfg_kernel_size == KERNEL_SIZE_WIDTH'(5);
   assign in_ready         = en && state != IDLE && fill_cnt < kk;
   assign wr               = in_valid && in_ready;
   assign swap             = en && full && (state == FILL || state == STALL || (state == WAIT && conv_result_ready));
   assign conv_kernel_size = k;
   // A write landing on a swap edge belongs to the bank just released by the swap.
   assign wr_bank = fill_sel ^ swap;
   assign wr_slot = swap ? '0 : fill_cnt;
   // Next beat to present: play bank while streaming, otherwise beat 0 (or 1 on a
   // bubble-free WAIT swap, since beat 0 was already on the bus) of the fill bank.
   assign rd_bank = (state == PRIME || (state == STREAM && !last)) ? ~fill_sel : fill_sel;
   assign rd_idx  = (state == PRIME || (state == WAIT && swap)) ? AW'(1) :
                    (state == STREAM && !last) ? idx + AW'(1) : '0;
   always_ff @(posedge clk)
      if (wr) mem[wr_bank][wr_slot] <= in_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state           <= IDLE;
         fill_sel        <= 1'b0;
         fill_cnt        <= '0;
         idx             <= '0;
         k               <= '0;
         conv_rst_n      <= 1'b0;
         cfg_error       <= 1'b0;
         underrun        <= 1'b0;
         conv_input_data <= '0;
         conv_weight     <= '0;
`ifdef CONV_FEEDER_STATS_EN
         window_count    <= '0;
`endif
      end else if (!en) begin
         state      <= IDLE;
         fill_cnt   <= '0;
         conv_rst_n <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         fill_cnt <= swap ? AW'(wr) : fill_cnt + AW'(wr);
         if (swap) fill_sel <= ~fill_sel;
         if (state != IDLE) {conv_weight, conv_input_data} <= mem[rd_bank][rd_idx];
         case (state)
            IDLE: begin
               k         <= cfg_kernel_size;
               cfg_error <= !legal;
               if (legal) state <= FILL;
            end
            FILL, STALL:
               if (swap) begin
                  state      <= PRIME;
                  conv_rst_n <= 1'b1;
               end
            PRIME: begin
               state <= STREAM;
               idx   <= AW'(1);
            end
            STREAM:
               if (last) state <= WAIT;
               else idx <= idx + AW'(1);
            WAIT:
               if (conv_result_ready) begin
`ifdef CONV_FEEDER_STATS_EN
                  window_count <= window_count + 16'd1;
`endif
                  if (full) begin
                     state <= STREAM;
                     idx   <= AW'(1);
                  end else begin
                     state      <= STALL;
                     underrun   <= 1'b1;
                     conv_rst_n <= 1'b0;
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: randomized self-checking bench for conv_window_feeder
module tb_conv_window_feeder;
   localparam int DW = 16;
   localparam int PX = 3;
   localparam int PY = 3;
   localparam int KM = 5;
   localparam int KW = 3;
   localparam int BW = PX*PY*DW;
   localparam int W  = BW+DW;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          in_valid = 1'b0;
   logic          conv_result_ready = 1'b0;
   logic [KW-1:0] cfg_kernel_size = '0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, conv_rst_n, cfg_error, underrun;
   logic [BW-1:0] conv_input_data;
   logic [DW-1:0] conv_weight;
   logic [KW-1:0] conv_kernel_size;
`ifdef CONV_FEEDER_STATS_EN
   logic [15:0]   window_count;
`endif
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   conv_window_feeder #(.DATA_WIDTH(DW), .PARA_X(PX), .PARA_Y(PY), .KERNEL_SIZE_MAX(KM), .KERNEL_SIZE_WIDTH(KW)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .cfg_kernel_size(cfg_kernel_size),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .conv_rst_n(conv_rst_n),
      .conv_input_data(conv_input_data),
      .conv_weight(conv_weight),
      .conv_kernel_size(conv_kernel_size),
      .conv_result_ready(conv_result_ready),
      .cfg_error(cfg_error),
`ifdef CONV_FEEDER_STATS_EN
      .window_count(window_count),
`endif
      .underrun(underrun)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] b;
      for (int j = 0; j < W; j += 32) b[j+:32] = $urandom;
      return b;
   endfunction
   // Window-level reference: beats accepted upstream are issued in order, K*K per window,
   // one per cycle; between windows the next window's beat 0 is held until the result
   // pulse, then either beat 1 follows at once (window complete) or underrun is flagged.
   task automatic run(input int kin, input int nwin, input int vpct, input int dly, input bit starve, output int und_seen);
      int kk, cw, pos, phase, wcnt, dcur, sent, prev, ix;
      bit hs, rdy, full_next, pulsed, exp_und, done;
      logic [W-1:0] src[$];
      logic [W-1:0] acc[$];
      logic [W-1:0] exp_b;
`ifdef CONV_FEEDER_STATS_EN
      logic [15:0] wc0;
      int npul;
      npul = 0;
`endif
      kk = kin*kin; cw = 0; pos = 0; phase = 0; wcnt = 0; sent = 0;
      pulsed = 0; done = 0; und_seen = 0;
      dcur = dly < 0 ? int'($urandom_range(0, 6)) : dly;
      for (int i = 0; i < nwin*kk; i++) src.push_back(rand_beat());
      en = 0; in_valid = 0; conv_result_ready = 0;
      tick();
`ifdef CONV_FEEDER_STATS_EN
      wc0 = window_count;
`endif
      cfg_kernel_size = KW'(kin);
      en = 1;
      for (int c = 0; c < 3000 && !done; c++) begin
         in_valid = sent < nwin*kk && !(starve && sent == 2*kk-1 && !pulsed) && int'($urandom_range(0, 99)) < vpct;
         in_data = sent < src.size() ? src[sent] : '0;
         conv_result_ready = phase == 2 && wcnt == dcur;
         @(negedge clk);
         hs = in_valid && in_ready;
         rdy = conv_result_ready;
         full_next = acc.size() >= (cw+2)*kk;
         prev = acc.size();
         tick();
         if (hs) begin
            acc.push_back(src[sent]);
            sent++;
         end
         if (rdy) pulsed = 1;
`ifdef CONV_FEEDER_STATS_EN
         if (rdy) npul++;
`endif
         if (underrun) und_seen++;
         exp_und = 0;
         case (phase)
            0: if (conv_rst_n) begin
               phase = 1;
               pos = 0;
               total++;
               if (acc.size() < (cw+1)*kk) begin
                  bad++;
                  $display("FAIL early_prime: accepted=%0d required=%0d", acc.size(), (cw+1)*kk);
               end
            end
            1: if (pos == kk-1) begin
               phase = 2;
               wcnt = 0;
               dcur = dly < 0 ? int'($urandom_range(0, 6)) : dly;
               if (cw == nwin-1) done = 1;
            end else pos++;
            2: if (rdy) begin
               cw++;
               if (full_next) begin
                  phase = 1;
                  pos = 1;
               end else begin
                  phase = 0;
                  exp_und = 1;
               end
            end else wcnt++;
            default: phase = 0;
         endcase
         total++;
         if (underrun !== exp_und) begin
            bad++;
            $display("FAIL underrun: got=%b exp=%b (window %0d)", underrun, exp_und, cw);
         end
         if (phase == 0 && exp_und) begin
            total++;
            if (conv_rst_n !== 1'b0) begin
               bad++;
               $display("FAIL stall_rst_n: got=%b exp=0", conv_rst_n);
            end
         end
         if (phase == 1) begin
            ix = cw*kk + pos;
            exp_b = ix < acc.size() ? acc[ix] : 'x;
            total++;
            if (conv_rst_n !== 1'b1 || {conv_weight, conv_input_data} !== exp_b) begin
               bad++;
               $display("FAIL beat w%0d b%0d: rst_n=%b got=%h exp=%h", cw, pos, conv_rst_n, {conv_weight, conv_input_data}, exp_b);
            end
            total++;
            if (conv_kernel_size !== KW'(kin)) begin
               bad++;
               $display("FAIL kernel_size: got=%0d exp=%0d", conv_kernel_size, kin);
            end
         end
         if (phase == 2) begin
            total++;
            if (conv_rst_n !== 1'b1) begin
               bad++;
               $display("FAIL wait_rst_n: got=%b exp=1", conv_rst_n);
            end
            if (cw < nwin-1 && prev > (cw+1)*kk) begin
               total++;
               if ({conv_weight, conv_input_data} !== acc[(cw+1)*kk]) begin
                  bad++;
                  $display("FAIL wait_beat0: got=%h exp=%h", {conv_weight, conv_input_data}, acc[(cw+1)*kk]);
               end
            end
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL run_timeout: windows_done=%0d required=%0d", cw, nwin);
      end
`ifdef CONV_FEEDER_STATS_EN
      total++;
      if (window_count !== wc0 + 16'(npul)) begin
         bad++;
         $display("FAIL window_count: got=%0d exp=%0d", window_count, wc0 + 16'(npul));
      end
`endif
      conv_result_ready = 0;
      in_valid = 0;
   endtask
   task automatic test_reset();
      #1 rst = 0;
      tick();
      tick();
      total += 7;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got=%b exp=0", in_ready); end
      if (conv_rst_n !== 1'b0) begin bad++; $display("FAIL rst_conv_rst_n: got=%b exp=0", conv_rst_n); end
      if (cfg_error !== 1'b0) begin bad++; $display("FAIL rst_cfg_error: got=%b exp=0", cfg_error); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got=%b exp=0", underrun); end
      if (conv_input_data !== '0) begin bad++; $display("FAIL rst_data: got=%h exp=0", conv_input_data); end
      if (conv_weight !== '0) begin bad++; $display("FAIL rst_weight: got=%h exp=0", conv_weight); end
      if (conv_kernel_size !== '0) begin bad++; $display("FAIL rst_ksize: got=%0d exp=0", conv_kernel_size); end
      @(negedge clk) rst = 1;
      tick();
   endtask
   task automatic test_cfg_error();
      en = 0; in_valid = 1; in_data = rand_beat(); cfg_kernel_size = 3'd4;
      tick();
      en = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total += 3;
         if (cfg_error !== 1'b1) begin bad++; $display("FAIL cfg_error_set: got=%b exp=1", cfg_error); end
         if (in_ready !== 1'b0) begin bad++; $display("FAIL cfg_in_ready: got=%b exp=0", in_ready); end
         if (conv_rst_n !== 1'b0) begin bad++; $display("FAIL cfg_rst_n: got=%b exp=0", conv_rst_n); end
      end
      en = 0;
      tick();
      total++;
      if (cfg_error !== 1'b1) begin bad++; $display("FAIL cfg_error_hold: got=%b exp=1", cfg_error); end
      cfg_kernel_size = 3'd3; en = 1;
      tick();
      total += 2;
      if (cfg_error !== 1'b0) begin bad++; $display("FAIL cfg_error_clear: got=%b exp=0", cfg_error); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL cfg_fill_ready: got=%b exp=1", in_ready); end
      en = 0; in_valid = 0;
   endtask
   task automatic test_stream_k3();
      int u;
      run(3, 2, 100, 3, 0, u);
      total++;
      if (u != 0) begin bad++; $display("FAIL k3_underrun_count: got=%0d exp=0", u); end
   endtask
   task automatic test_starve_k5();
      int u;
      run(5, 2, 100, 2, 1, u);
      total++;
      if (u != 1) begin bad++; $display("FAIL k5_underrun_count: got=%0d exp=1", u); end
   endtask
   task automatic test_abort();
      int c, u;
      en = 0; in_valid = 0;
      tick();
      cfg_kernel_size = 3'd3; en = 1; in_valid = 1;
      c = 0;
      while (conv_rst_n !== 1'b1 && c < 50) begin
         in_data = rand_beat();
         tick();
         c++;
      end
      total++;
      if (conv_rst_n !== 1'b1) begin bad++; $display("FAIL abort_prime_timeout: rst_n=%b exp=1", conv_rst_n); end
      repeat (5) begin
         in_data = rand_beat();
         tick();
      end
      en = 0;
      tick();
      total += 2;
      if (conv_rst_n !== 1'b0) begin bad++; $display("FAIL abort_rst_n: got=%b exp=0", conv_rst_n); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready: got=%b exp=0", in_ready); end
      in_valid = 0;
      run(3, 2, 100, 1, 0, u);
   endtask
   task automatic test_async_reset();
      int u;
      en = 0; in_valid = 0;
      tick();
      cfg_kernel_size = 3'd3; en = 1;
      tick();
      in_valid = 1;
      repeat (4) begin
         in_data = rand_beat();
         tick();
      end
      #2 rst = 0;
      #1;
      total += 7;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_in_ready: got=%b exp=0", in_ready); end
      if (conv_rst_n !== 1'b0) begin bad++; $display("FAIL arst_conv_rst_n: got=%b exp=0", conv_rst_n); end
      if (cfg_error !== 1'b0) begin bad++; $display("FAIL arst_cfg_error: got=%b exp=0", cfg_error); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL arst_underrun: got=%b exp=0", underrun); end
      if (conv_input_data !== '0) begin bad++; $display("FAIL arst_data: got=%h exp=0", conv_input_data); end
      if (conv_weight !== '0) begin bad++; $display("FAIL arst_weight: got=%h exp=0", conv_weight); end
      if (conv_kernel_size !== '0) begin bad++; $display("FAIL arst_ksize: got=%0d exp=0", conv_kernel_size); end
      in_valid = 0; en = 0;
      @(negedge clk) rst = 1;
      run(3, 2, 70, -1, 0, u);
   endtask
   task automatic test_random();
      int u;
      for (int i = 0; i < 4; i++)
         run($urandom_range(0, 1) ? 5 : 3, 4, int'($urandom_range(40, 100)), -1, 0, u);
   endtask
   initial begin
      test_reset();
      test_cfg_error();
      test_stream_k3();
      test_starve_k5();
      test_abort();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one fp16 element and of the weight.
REQ-002 Parameter PARA_X, default 3; parameter PARA_Y, default 3: output tile rows and columns, so a data beat is PARA_X*PARA_Y*DATA_WIDTH bits (BEAT_W).
REQ-003 Parameter KERNEL_SIZE_MAX, default 5; parameter KERNEL_SIZE_WIDTH, default 3.
REQ-004 Ports clk (input, 1 bit, clock) and rst (input, 1 bit, reset) SHALL be as follows: reset rst, asynchronous, active-low; clock clk.
REQ-005 en, input, 1: enable; 0 = abort and idle.
REQ-006 cfg_kernel_size, input, KERNEL_SIZE_WIDTH: requested kernel size; legal values are 3 and 5.
REQ-007 in_valid, input, 1; in_ready, output, 1: upstream beat handshake.
REQ-008 in_data, input, BEAT_W+DATA_WIDTH: upstream beat; the upper DATA_WIDTH bits are the weight, the lower BEAT_W bits are the data.
REQ-009 conv_rst_n, output, 1: active-low run/reset to the convolution unit.
REQ-010 conv_input_data, output, BEAT_W; conv_weight, output, DATA_WIDTH; conv_kernel_size, output, KERNEL_SIZE_WIDTH.
REQ-011 conv_result_ready, input, 1: result pulse from the convolution unit.
REQ-012 cfg_error, output, 1; underrun, output, 1.

Function
REQ-013 The block SHALL hold two window banks (ping-pong), each KERNEL_SIZE_MAX^2 beats deep; one bank is the fill bank and the other is the play bank.
REQ-014 Fill: in_ready=1 while en=1, state!=IDLE, and the fill bank holds fewer than K*K beats; each in_valid&in_ready edge writes the next slot (0..K*K-1).
REQ-015 States SHALL be IDLE, FILL, PRIME, STREAM, WAIT and STALL.
REQ-016 IDLE: conv_rst_n=0; when en=1, latch cfg_kernel_size into K and go to FILL if K is 3 or 5; otherwise set cfg_error=1 and stay in IDLE.
REQ-017 FILL/STALL: conv_rst_n=0; once the fill bank is full, swap banks, drive conv_rst_n<=1, and go to PRIME.
REQ-018 PRIME: present beat 0 of the play bank; on the next edge go to STREAM with index=1.
REQ-019 STREAM: present beat[index] on every cycle and advance index on every edge; after the edge that presents K*K-1, go to WAIT.
REQ-020 WAIT: present beat 0 of the fill bank.
REQ-021 In WAIT, when conv_result_ready is sampled 1 and the fill bank is full: swap banks and go to STREAM with index=1, with no bubble.
REQ-022 In WAIT, when conv_result_ready is sampled 1 and the fill bank is not full: pulse underrun for 1 cycle, drive conv_rst_n<=0, and go to STALL.
REQ-023 Beat issue SHALL follow the convolution unit's schedule: one beat per cycle, beat n paired with the weight of beat n; beats are streamed unmodified.
REQ-024 The block SHALL NOT select lanes or reorder data; upstream supplies beats already lane-packed per beat type (0: full tile, 1..K-1: one element per row, multiple of K: PARA_Y elements, other: one element).
REQ-025 conv_kernel_size SHALL equal K whenever conv_rst_n=1; K SHALL change only in IDLE.
REQ-026 A bank swap and a fill write occurring on the same edge SHALL target the newly freed bank starting at slot 0.
REQ-027 en=0 in any state: on the next edge go to IDLE, conv_rst_n=0, both banks empty, in_ready=0; a beat offered on that edge is dropped.

Reset
REQ-028 When rst=0, the block SHALL enter IDLE with conv_rst_n=0, in_ready=0, cfg_error=0, underrun=0, conv_input_data=0, conv_weight=0, conv_kernel_size=0, and both banks empty.
REQ-029 Reset SHALL take effect asynchronously mid-window and SHALL discard any partial window.
REQ-030 cfg_error SHALL clear only on reset or on a transition from IDLE with a legal K.

Configuration
REQ-031 With CONV_FEEDER_STATS_EN defined, the block SHALL add output window_count (16 bits), reset 0, incremented on each WAIT exit via conv_result_ready, and wrapping 0xFFFF->0.
REQ-032 Without CONV_FEEDER_STATS_EN defined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Scenario: K=3, 18 beats streamed continuously, conv_result_ready pulsed 4 cycles after the 9th beat is issued -> 9 consecutive beats issued, WAIT, then beat 1 of window 2 on the cycle after the pulse; underrun never asserts.
REQ-034 Scenario: K=5, only 24 beats of window 2 available at conv_result_ready -> underrun pulses once, conv_rst_n=0 until beat 25 is accepted, then PRIME, and window 2 issues beats 0..24 in order.
REQ-035 Scenario: cfg_kernel_size=4 with en=1 -> cfg_error=1, state stays IDLE, in_ready=0, conv_rst_n=0.
REQ-036 Scenario: en dropped at STREAM index 5 -> next cycle conv_rst_n=0, in_ready=0; re-enabling with K=3 requires 9 fresh beats before PRIME.
REQ-037 Scenario: rst asserted during FILL slot 4 -> all outputs at reset values immediately.
REQ-038 Scenario: with CONV_FEEDER_STATS_EN defined, 65537 K=3 windows completed -> window_count=1.
